// File: rtl/cory_mux4_queue_if.sv
// Handshake bundle for the 4:1 select-stream mux: four data inputs, a select
// stream, and one output stream carrying data plus the source index.
interface cory_mux4_queue_if #(
  parameter int N = 8
);
  logic         i_a0_v, i_a1_v, i_a2_v, i_a3_v;
  logic [N-1:0] i_a0_d, i_a1_d, i_a2_d, i_a3_d;
  logic         o_a0_r, o_a1_r, o_a2_r, o_a3_r;
  logic         i_s_v;
  logic [1:0]   i_s_d;
  logic         o_s_r;
  logic         o_z_v;
  logic [N-1:0] o_z_d;
  logic [1:0]   o_z_s;
  logic         i_z_r;

  modport master (
    output i_a0_v, i_a1_v, i_a2_v, i_a3_v,
    output i_a0_d, i_a1_d, i_a2_d, i_a3_d,
    input  o_a0_r, o_a1_r, o_a2_r, o_a3_r,
    output i_s_v, i_s_d,
    input  o_s_r,
    input  o_z_v, o_z_d, o_z_s,
    output i_z_r
  );

  modport slave (
    input  i_a0_v, i_a1_v, i_a2_v, i_a3_v,
    input  i_a0_d, i_a1_d, i_a2_d, i_a3_d,
    output o_a0_r, o_a1_r, o_a2_r, o_a3_r,
    input  i_s_v, i_s_d,
    output o_s_r,
    output o_z_v, o_z_d, o_z_s,
    input  i_z_r
  );
endinterface

// File: rtl/cory_mux4_queue.sv
// Select-stream driven 4:1 mux; one select token consumed per forwarded word.
// Optional Q-entry output FIFO (Q=0 gives a purely combinational path).
module cory_mux4_queue #(
  parameter int N = 8,
  parameter int Q = 0
) (
  input  logic clk,
  input  logic reset_n,
  cory_mux4_queue_if.slave s_if
);
  logic [3:0]        w_a_v;
  logic [3:0][N-1:0] w_a_d;
  logic [3:0]        w_a_r;
  logic              w_int_v;
  logic              w_int_r;
  logic [N+1:0]      w_int_pkt;
  logic              w_z_v;
  logic [N+1:0]      w_z_pkt;

  assign w_a_v = {s_if.i_a3_v, s_if.i_a2_v, s_if.i_a1_v, s_if.i_a0_v};
  assign w_a_d = {s_if.i_a3_d, s_if.i_a2_d, s_if.i_a1_d, s_if.i_a0_d};

  assign w_int_v   = s_if.i_s_v & w_a_v[s_if.i_s_d];
  assign w_int_pkt = {s_if.i_s_d, w_a_d[s_if.i_s_d]};

  // Only the selected input sees ready, and only while a select token is present
  assign w_a_r = (s_if.i_s_v & w_int_r) ? (4'b0001 << s_if.i_s_d) : 4'b0000;
  assign s_if.o_s_r = w_a_v[s_if.i_s_d] & w_int_r;

  assign s_if.o_a0_r = w_a_r[0];
  assign s_if.o_a1_r = w_a_r[1];
  assign s_if.o_a2_r = w_a_r[2];
  assign s_if.o_a3_r = w_a_r[3];

  generate
    if (Q == 0) begin : g_pass
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ reset_n;
      assign w_z_v   = w_int_v;
      assign w_z_pkt = w_int_pkt;
      assign w_int_r = s_if.i_z_r;
    end else begin : g_fifo
      localparam int PW = (Q > 1) ? $clog2(Q) : 1;
      localparam int CW = $clog2(Q + 1);

      logic [N+1:0] r_mem [Q];
      logic [PW-1:0] r_wptr, r_rptr;
      logic [CW-1:0] r_cnt;
      logic w_full, w_empty, w_push, w_pop;

      assign w_full  = (r_cnt == CW'(Q));
      assign w_empty = (r_cnt == '0);
      // No bypass: a full queue refuses input even while it is being drained
      assign w_int_r = ~w_full;
      assign w_push  = w_int_v & w_int_r;
      assign w_pop   = ~w_empty & s_if.i_z_r;
      assign w_z_v   = ~w_empty;
      assign w_z_pkt = r_mem[r_rptr];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push) r_wptr <= (r_wptr == PW'(Q - 1)) ? '0 : r_wptr + 1'b1;
          if (w_pop)  r_rptr <= (r_rptr == PW'(Q - 1)) ? '0 : r_rptr + 1'b1;
          case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end

      // Storage is deliberately not reset; head contents only matter when valid
      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_int_pkt;
      end
    end
  endgenerate

  assign s_if.o_z_v = w_z_v;
  assign s_if.o_z_d = w_z_pkt[N-1:0];
  assign s_if.o_z_s = w_z_pkt[N+1:N];
endmodule

// File: tb/tb_cory_mux4_queue.sv
// Drives identical stimulus into four instances (Q=0,1,2,4) and checks each
// against a queue-based reference model, plus directed corner scenarios.
module tb_cory_mux4_queue;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [3:0]       a_v;
  logic [3:0][7:0]  a_d;
  logic             s_v;
  logic [1:0]       s_d;
  logic             z_r;

  logic [3:0]       zv;
  logic [3:0][7:0]  zd;
  logic [3:0][1:0]  zs;
  logic [3:0][3:0]  ar;
  logic [3:0]       sr;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int QG = (g == 3) ? 4 : g;
    cory_mux4_queue_if #(.N(8)) bus ();
    assign bus.i_a0_v = a_v[0];
    assign bus.i_a1_v = a_v[1];
    assign bus.i_a2_v = a_v[2];
    assign bus.i_a3_v = a_v[3];
    assign bus.i_a0_d = a_d[0];
    assign bus.i_a1_d = a_d[1];
    assign bus.i_a2_d = a_d[2];
    assign bus.i_a3_d = a_d[3];
    assign bus.i_s_v  = s_v;
    assign bus.i_s_d  = s_d;
    assign bus.i_z_r  = z_r;
    assign zv[g] = bus.o_z_v;
    assign zd[g] = bus.o_z_d;
    assign zs[g] = bus.o_z_s;
    assign sr[g] = bus.o_s_r;
    assign ar[g] = {bus.o_a3_r, bus.o_a2_r, bus.o_a1_r, bus.o_a0_r};
    cory_mux4_queue #(.N(8), .Q(QG)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .s_if    (bus.slave)
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] mq [4][$];
  logic [3:0] m_push, m_pop;

  function automatic int qd(int k);
    return (k == 3) ? 4 : k;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected behaviour straight from the handshake rules: a bounded FIFO of {sel,data}
  task automatic compare_all();
    int q;
    logic iv, ir, ev;
    logic [9:0] ep;
    logic [3:0] exp_ar;
    for (int k = 0; k < 4; k++) begin
      q  = qd(k);
      iv = s_v & a_v[s_d];
      if (q == 0) begin
        ir = z_r; ev = iv; ep = {s_d, a_d[s_d]};
      end else begin
        ir = (mq[k].size() < q);
        ev = (mq[k].size() > 0);
        ep = ev ? mq[k][0] : 10'h0;
      end
      exp_ar = (s_v && ir) ? (4'b0001 << s_d) : 4'b0000;
      chk($sformatf("q%0d_z_v", q), 32'(zv[k]), 32'(ev));
      if (ev) begin
        chk($sformatf("q%0d_z_d", q), 32'(zd[k]), 32'(ep[7:0]));
        chk($sformatf("q%0d_z_s", q), 32'(zs[k]), 32'(ep[9:8]));
      end
      chk($sformatf("q%0d_a_r", q), 32'(ar[k]), 32'(exp_ar));
      chk($sformatf("q%0d_s_r", q), 32'(sr[k]), 32'(a_v[s_d] & ir));
      m_push[k] = (q > 0) && iv && ir;
      m_pop[k]  = (q > 0) && ev && z_r;
    end
  endtask

  task automatic pre();
    @(negedge clk);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (m_pop[k])  void'(mq[k].pop_front());
      if (m_push[k]) mq[k].push_back({s_d, a_d[s_d]});
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_v = '0; a_d = '0; s_v = 1'b0; s_d = 2'd0; z_r = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    for (int k = 1; k < 4; k++) chk($sformatf("rst_async_q%0d_z_v", qd(k)), 32'(zv[k]), 32'h0);
    for (int k = 0; k < 4; k++) mq[k].delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int seq [3];
    reset_n = 1'b0;
    idle_inputs();
    #1;
    for (int k = 1; k < 4; k++) chk($sformatf("rst_q%0d_z_v", qd(k)), 32'(zv[k]), 32'h0);
    // Q=0 stays combinational while reset is held
    s_v = 1'b1; s_d = 2'd2; a_v = 4'b0100; a_d[2] = 8'h5A; z_r = 1'b1;
    #1;
    chk("rst_q0_z_v", 32'(zv[0]), 32'h1);
    chk("rst_q0_z_d", 32'(zd[0]), 32'h5A);
    chk("rst_q0_a_r", 32'(ar[0]), 32'b0100);
    for (int k = 1; k < 4; k++) chk($sformatf("rst_q%0d_z_v_held", qd(k)), 32'(zv[k]), 32'h0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    pre();
    for (int k = 1; k < 4; k++) chk($sformatf("post_rst_q%0d_s_ready", qd(k)), 32'(ar[k]), 32'h0);
    adv();

    // Q=0 pass-through of input 2
    s_v = 1'b1; s_d = 2'd2; a_v = 4'b0100; a_d = '0; a_d[2] = 8'h5A; z_r = 1'b1;
    pre();
    chk("q0_pass_v", 32'(zv[0]), 32'h1);
    chk("q0_pass_d", 32'(zd[0]), 32'h5A);
    chk("q0_pass_s", 32'(zs[0]), 32'h2);
    chk("q0_pass_ar", 32'(ar[0]), 32'b0100);
    chk("q0_pass_sr", 32'(sr[0]), 32'h1);
    adv();

    // Q=0 selected input idle while another is valid
    s_d = 2'd1; a_v = 4'b1000;
    pre();
    chk("q0_unsel_v", 32'(zv[0]), 32'h0);
    chk("q0_unsel_sr", 32'(sr[0]), 32'h0);
    chk("q0_unsel_a3r", 32'(ar[0][3]), 32'h0);
    adv();

    // Q=2 fill while stalled, then drain in order
    do_reset();
    s_v = 1'b1; s_d = 2'd0; a_v = 4'b0001; z_r = 1'b0;
    a_d[0] = 8'h11; pre(); chk("q2_fill0_r", 32'(ar[2][0]), 32'h1); adv();
    a_d[0] = 8'h22; pre(); chk("q2_fill1_r", 32'(ar[2][0]), 32'h1); adv();
    a_d[0] = 8'h33; pre(); chk("q2_full_r", 32'(ar[2][0]), 32'h0); adv();
    z_r = 1'b1;
    pre();
    chk("q2_drain0_d", 32'(zd[2]), 32'h11);
    chk("q2_drain0_s", 32'(zs[2]), 32'h0);
    chk("q2_full_pop_r", 32'(ar[2][0]), 32'h0);
    adv();
    pre(); chk("q2_drain1_d", 32'(zd[2]), 32'h22); chk("q2_drain1_r", 32'(ar[2][0]), 32'h1); adv();
    a_v = 4'b0000;
    pre(); chk("q2_drain2_v", 32'(zv[2]), 32'h1); chk("q2_drain2_d", 32'(zd[2]), 32'h33); adv();
    pre(); chk("q2_empty_v", 32'(zv[2]), 32'h0); adv();

    // Q=2 streaming at full rate with select sequence 3,0,3
    do_reset();
    seq = '{3, 0, 3};
    a_v = 4'b1111; a_d = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; z_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_v = (i < 3);
      s_d = (i < 3) ? 2'(seq[i]) : 2'd0;
      pre();
      if (i == 0 || i == 4) chk("q2_stream_v", 32'(zv[2]), 32'h0);
      else begin
        chk("q2_stream_v", 32'(zv[2]), 32'h1);
        chk("q2_stream_s", 32'(zs[2]), 32'(seq[i-1]));
      end
      adv();
    end

    // Q=1 runs at half rate when continuously offered
    do_reset();
    s_v = 1'b1; s_d = 2'd1; a_v = 4'b0010; z_r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_d[1] = 8'(i + 1);
      pre();
      chk("q1_half_v", 32'(zv[1]), 32'(i % 2));
      adv();
    end

    // Q=4 holding 3 words, reset mid-operation discards them
    do_reset();
    s_v = 1'b1; s_d = 2'd3; a_v = 4'b1000; z_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_d[3] = 8'(8'h40 + i);
      pre(); adv();
    end
    pre();
    chk("q4_three_queued_v", 32'(zv[3]), 32'h1);
    s_v = 1'b0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      pre();
      chk("q4_after_rst_v", 32'(zv[3]), 32'h0);
      adv();
    end

    // Random traffic, first with a mostly-ready sink, then mostly stalled
    for (int i = 0; i < 600; i++) begin
      s_v = ($urandom % 4) != 0;
      s_d = 2'($urandom);
      a_v = 4'($urandom);
      a_d = 32'($urandom);
      z_r = (i < 350) ? (($urandom % 3) != 0) : (($urandom % 4) == 0);
      pre();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
